// File: rtl/data_mem_responder_pkg.sv
// Shared types and codes for the data memory responder.
// Error causes and sweep FSM state encodings.
package data_mem_responder_pkg;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RANGE    = 2'b01;
    localparam logic [1:0] ERR_INIT     = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    typedef enum logic {
        MEMST_CLEAR = 1'b0,
        MEMST_READY = 1'b1
    } memst_e;

endpackage

// File: rtl/mem_init_sequencer.sv
// Post-reset clear sweep: walks every RAM word once,
// then parks in READY until the next reset.
module mem_init_sequencer
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_busy,
    output logic             clr_we,
    output logic [PTR_W-1:0] clr_addr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    memst_e           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic             busy_q;

    // Sweep FSM with pointer and registered busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MEMST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                MEMST_CLEAR: begin
                    if (ptr_q == LAST) begin
                        state_q <= MEMST_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                MEMST_READY: begin
                    state_q <= MEMST_READY;
                end
                default: begin
                    state_q <= MEMST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy = busy_q;
    assign clr_we    = (state_q == MEMST_CLEAR);
    assign clr_addr  = ptr_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder on the shared data bus: windowed RAM,
// combinational tri-state reads and a sticky error register.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter int          ADDR_WIDTH     = 16,
    parameter int unsigned MEM_START_ADDR = 'h40,
    parameter int unsigned MEM_STOP_ADDR  = 'hBF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  mem_cs,
    input  logic                  mem_we,
    input  logic                  mem_oe,
    input  logic                  error_clear,
    output logic                  init_busy,
    output logic                  bus_error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH-1:0] error_addr
);

    localparam int DEPTH = int'(MEM_STOP_ADDR - MEM_START_ADDR) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(MEM_START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STOP_A  = ADDR_WIDTH'(MEM_STOP_ADDR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             clr_we;
    logic [PTR_W-1:0] clr_addr;
    logic             ready;
    logic             hit;
    logic [PTR_W-1:0] idx;
    logic             wr_en;
    logic             rd_en;
    logic             err_any;
    logic [1:0]       err_cause;

    logic                  bus_error_q, bus_error_d;
    logic [1:0]            error_code_q, error_code_d;
    logic [ADDR_WIDTH-1:0] error_addr_q, error_addr_d;

    mem_init_sequencer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign ready = ~init_busy;
    assign hit   = (bus_addr >= START_A) && (bus_addr <= STOP_A);
    assign idx   = PTR_W'(bus_addr - START_A);
    assign wr_en = ready & mem_cs & mem_we & ~mem_oe & hit;
    assign rd_en = ready & mem_cs & mem_oe & ~mem_we & hit;

    // Error cause with init > conflict > out-of-window priority
    always_comb begin
        err_any   = 1'b0;
        err_cause = ERR_NONE;
        if (mem_cs && (mem_we || mem_oe)) begin
            if (!ready) begin
                err_any   = 1'b1;
                err_cause = ERR_INIT;
            end else if (mem_we && mem_oe) begin
                err_any   = 1'b1;
                err_cause = ERR_CONFLICT;
            end else if (!hit) begin
                err_any   = 1'b1;
                err_cause = ERR_RANGE;
            end
        end
    end

    // Sticky capture; a clear makes room for a coincident new error
    always_comb begin
        bus_error_d  = bus_error_q;
        error_code_d = error_code_q;
        error_addr_d = error_addr_q;
        if (error_clear) begin
            bus_error_d  = 1'b0;
            error_code_d = ERR_NONE;
            error_addr_d = '0;
        end
        if (err_any && (!bus_error_q || error_clear)) begin
            bus_error_d  = 1'b1;
            error_code_d = err_cause;
            error_addr_d = bus_addr;
        end
    end

    // Error status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_error_q  <= 1'b0;
            error_code_q <= ERR_NONE;
            error_addr_q <= '0;
        end else begin
            bus_error_q  <= bus_error_d;
            error_code_q <= error_code_d;
            error_addr_q <= error_addr_d;
        end
    end

    // RAM write port: sweep zeroing has the port while busy
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[idx] <= bus_data;
        end
    end

    assign bus_data   = rd_en ? mem[idx] : 'z;
    assign bus_error  = bus_error_q;
    assign error_code = error_code_q;
    assign error_addr = error_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Undriven bus floats high through a pull-up net.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus_addr = '0;
    logic        mem_cs = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_oe = 1'b0;
    logic        error_clear = 1'b0;
    logic        drv_en = 1'b0;
    logic [7:0]  drv_val = '0;

    tri1 [7:0]   bus_data;
    wire         init_busy;
    wire         bus_error;
    wire [1:0]   error_code;
    wire [15:0]  error_addr;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model [0:255];
    int          n;

    assign bus_data = drv_en ? drv_val : 'z;

    data_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .error_clear (error_clear),
        .init_busy   (init_busy),
        .bus_error   (bus_error),
        .error_code  (error_code),
        .error_addr  (error_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_oe      = 1'b0;
        drv_en      = 1'b0;
        error_clear = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        idle();
        #1;
        chk("idle_z", bus_data, 8'hFF);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_oe   = 1'b0;
        drv_en   = 1'b1;
        drv_val  = d;
        model[a[7:0]] = d;
        idle_cycle();
    endtask

    task automatic rd(input string tag, input logic [15:0] a);
        @(negedge clk);
        bus_addr = a;
        mem_cs   = 1'b1;
        mem_we   = 1'b0;
        mem_oe   = 1'b1;
        exp_q.push_back(model[a[7:0]]);
        #2;
        chk(tag, bus_data, exp_q.pop_front());
        idle_cycle();
    endtask

    // One faulty or special access, held for a single edge
    task automatic acc(input logic [15:0] a, input logic we, input logic oe,
                       input logic [7:0] d, input logic clr);
        @(negedge clk);
        bus_addr    = a;
        mem_cs      = 1'b1;
        mem_we      = we;
        mem_oe      = oe;
        drv_en      = we;
        drv_val     = d;
        error_clear = clr;
        #2;
        if (!we) chk("err_acc_z", bus_data, 8'hFF);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!init_busy) break;
        end
    endtask

    initial begin
        idle();
        model_zero();
        #12;
        chk("rst_busy", init_busy, 1);
        chk("rst_err", bus_error, 0);
        chk("rst_code", error_code, 2'b00);
        chk("rst_addr", error_addr, 16'h0);
        chk("rst_z", bus_data, 8'hFF);

        @(negedge clk);
        reset = 1'b0;
        wait_sweep(n);
        chk("sweep_len", n, 128);

        rd("rd_40_zero", 16'h0040);
        rd("rd_7f_zero", 16'h007F);
        rd("rd_bf_zero", 16'h00BF);

        wr(16'h0040, 8'hA5);
        wr(16'h00BF, 8'h3C);
        rd("rd_40_a5", 16'h0040);
        rd("rd_bf_3c", 16'h00BF);

        acc(16'h003F, 1'b1, 1'b0, 8'h11, 1'b0);
        chk("range_flag", bus_error, 1);
        chk("range_code", error_code, 2'b01);
        chk("range_addr", error_addr, 16'h003F);
        acc(16'h00C0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("sticky_code", error_code, 2'b01);
        chk("sticky_addr", error_addr, 16'h003F);
        rd("rd_40_kept", 16'h0040);

        @(negedge clk);
        error_clear = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("clr_flag", bus_error, 0);
        chk("clr_code", error_code, 2'b00);
        chk("clr_addr", error_addr, 16'h0);

        wr(16'h0050, 8'h12);
        acc(16'h0050, 1'b1, 1'b1, 8'hFF, 1'b0);
        chk("conf_code", error_code, 2'b11);
        chk("conf_addr", error_addr, 16'h0050);
        rd("rd_50_prev", 16'h0050);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst2_err", bus_error, 0);
        chk("rst2_busy", init_busy, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (9) @(posedge clk);
        acc(16'h0060, 1'b1, 1'b0, 8'h99, 1'b0);
        chk("init_flag", bus_error, 1);
        chk("init_code", error_code, 2'b10);
        chk("init_addr", error_addr, 16'h0060);
        wait_sweep(n);
        chk("sweep_rest", n, 118);
        model_zero();
        rd("rd_60_drop", 16'h0060);

        acc(16'h0000, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("clrcap_flag", bus_error, 1);
        chk("clrcap_code", error_code, 2'b01);
        chk("clrcap_addr", error_addr, 16'h0000);

        wr(16'h0045, 8'h77);
        rd("rd_45_77", 16'h0045);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("mid_busy", init_busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_sweep(n);
        chk("sweep_again", n, 128);
        model_zero();
        rd("rd_45_zero", 16'h0045);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the control unit's data bus: `bus_addr`, `bus_data`, `mem_cs`, `mem_we`, `mem_oe`.
- Holds a data RAM decoded over the window `MEM_START_ADDR..MEM_STOP_ADDR`.
- Clears the RAM to zero with a hardware sweep after every reset.
- Drives `bus_data` only on a valid read and flags illegal accesses in a sticky error register.

## Interface
- `DATA_WIDTH`, 8, data/word width
- `ADDR_WIDTH`, 16, bus address width
- `MEM_START_ADDR`, 8'h40, first decoded address, inclusive
- `MEM_STOP_ADDR`, 8'hBF, last decoded address, inclusive; DEPTH = STOP-START+1 = 128
- Ports:
  - `clk`  in  1  single system clock, rising edge
  - `reset`  in  1  asynchronous, active-high
  - `bus_addr`  in  ADDR_WIDTH  access address
  - `bus_data`  inout  DATA_WIDTH  write data in; read data out, else high-Z
  - `mem_cs`  in  1  access select
  - `mem_we`  in  1  write strobe
  - `mem_oe`  in  1  read/output enable
  - `error_clear`  in  1  one-cycle pulse, clears error status
  - `init_busy`  out  1  high while the clear sweep runs
  - `bus_error`  out  1  sticky error flag
  - `error_code`  out  2  cause of first error: 01 out-of-window, 10 access during init, 11 we&oe conflict
  - `error_addr`  out  ADDR_WIDTH  `bus_addr` of the first error

## Operation
- FSM states:
  - CLEAR: write 0 to `mem[clr_ptr]` each cycle; `clr_ptr` increments; at `clr_ptr == DEPTH-1`, go to READY on the next edge.
  - READY: normal service; no exit except reset.
- Decode:
  - `hit` = `bus_addr >= MEM_START_ADDR && bus_addr <= MEM_STOP_ADDR`, compared on full ADDR_WIDTH with both parameters zero-extended.
  - `idx` = `(bus_addr - MEM_START_ADDR)` truncated to clog2(DEPTH) bits.
- Write, when READY & cs & we & !oe & hit: `mem[idx] <= bus_data` at the rising edge.
- Read, when READY & cs & oe & !we & hit:
  - `bus_data = mem[idx]`, combinational from the array, no registered latency.
  - High-Z in every other case, including during reset.
- Errors, evaluated only when `mem_cs` = 1. Priority: 10 (state CLEAR) > 11 (we&oe) > 01 (!hit with we or oe).
  - On an error the access is dropped: no write, `bus_data` stays Z.
- Sticky capture:
  - If `bus_error` = 0, the first error loads `error_code`/`error_addr` and sets `bus_error`.
  - Later errors are ignored until cleared.
  - `error_clear` with a simultaneous new error: the new error is captured (clear then capture).
  - `error_clear` alone: `bus_error` = 0, `error_code` = 00, `error_addr` = 0.
- `mem_cs` = 1 with `we` = `oe` = 0: no-op, no error.

## Timing
- Reset values: state CLEAR, `clr_ptr` = 0, `init_busy` = 1, `bus_error` = 0, `error_code` = 00, `error_addr` = 0, `bus_data` Z.
- RAM contents are not reset directly; they are zeroed by the sweep.
- Sweep takes exactly DEPTH clock edges after reset deassertion:
  - `init_busy` falls after the 128th edge.
  - The first serviced access is sampled at edge 129.
- Reset asserted mid-sweep or mid-operation: immediate return to CLEAR with `clr_ptr` = 0. The sweep restarts in full; partial contents are don't-care.
- Write latency: data is visible to a read in the cycle after the write edge; no same-cycle bypass.
- Read: combinational; valid within the same cycle as the address and strobes. The control unit samples it at its WB edge.
- Error flags update at the rising edge that samples the faulty access.
- `error_clear` is sampled at the rising edge.

## Structure
- Add to `defines.vh`:
  - `ERR_NONE`, `ERR_RANGE`, `ERR_INIT`, `ERR_CONFLICT` (2-bit codes)
  - `MEMST_CLEAR`, `MEMST_READY` state encodings
- Sub-module `mem_init_sequencer`: holds the FSM and `clr_ptr` counter, and outputs `init_busy`, `clr_we` and `clr_addr`.
- Top level contains: the array, address decode, the write mux (sweep vs. bus), the tri-state driver and the error register.

## Test plan
- Reset release, then poll `init_busy`:
  - `init_busy` = 1 for exactly 128 edges, then 0.
  - Reads of 0x40, 0x7F and 0xBF return 8'h00.
- Write 8'hA5 @0x40, then 8'h3C @0xBF, then read both:
  - Reads return A5 and 3C.
  - `bus_data` is Z in the idle cycles between accesses.
- Write 8'h11 @0x3F, then read @0xC0:
  - `bus_error` = 1, `error_code` = 01, `error_addr` = 0x003F.
  - Second error is not captured; `bus_data` stays Z.
- cs = we = oe = 1 @0x50 with `bus_data` = FF:
  - `error_code` = 11.
  - A later read of 0x50 returns its previous value.
- Access 0x60 during the sweep (edge 10):
  - Error code 10; the access is dropped.
  - `error_clear` pulsed together with a new out-of-window access @0x00: `error_code` = 01, `error_addr` = 0x0000.
- Write 8'h77 @0x45, then assert `reset` mid-sweep of a second reset cycle:
  - After the full 128-cycle sweep, 0x45 reads 00.
  - `init_busy` timing restarts from 0.
